// File: rtl/dma_probe_pkg.sv
// dma_trace_probe shared definitions
// register map, control bits, sequencer states
package dma_probe_pkg;

    localparam logic [15:0] OFF_ADDR   = 16'h0;
    localparam logic [15:0] OFF_DELAY  = 16'h2;
    localparam logic [15:0] OFF_CTRL   = 16'h4;
    localparam logic [15:0] OFF_STATUS = 16'h6;
    localparam logic [15:0] OFF_WDATA  = 16'h8;
    localparam logic [15:0] OFF_TRACE0 = 16'hA;
    localparam logic [15:0] OFF_TRACE1 = 16'hC;
    localparam logic [15:0] OFF_TRACE2 = 16'hE;

    localparam int NSAMP_WD   = 6;
    localparam int CTRL_WR    = 8;
    localparam int CTRL_INC   = 9;
    localparam int CTRL_IE    = 10;
    localparam int CTRL_ABORT = 14;
    localparam int CTRL_START = 15;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } state_e;

    function automatic bit trace_wd_ok(int wd);
        return (wd == 16) || (wd == 32) || (wd == 48);
    endfunction

endpackage

// File: rtl/dma_trace_probe_if.sv
// dma_trace_probe bus bundle
// peripheral slave port plus dma master port
interface dma_trace_probe_if;

    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;
    logic [14:0] dma_addr;
    logic [15:0] dma_dout;
    logic        dma_en;
    logic [1:0]  dma_we;
    logic        dma_ready;
    logic        irq;

    modport slave (
        input  per_addr, per_din, per_en, per_we, dma_ready,
        output per_dout, dma_addr, dma_dout, dma_en, dma_we, irq
    );

    modport master (
        output per_addr, per_din, per_en, per_we, dma_ready,
        input  per_dout, dma_addr, dma_dout, dma_en, dma_we, irq
    );

endinterface

// File: rtl/dma_probe_seq.sv
// dma_trace_probe sequencer
// start delay, burst counting, sample index
module dma_probe_seq
    import dma_probe_pkg::*;
#(
    parameter int TRACE_WD = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] delay,
    input  logic [5:0]  nsamp,
    output logic        dma_en,
    output logic        busy,
    output logic        done,
    output logic [5:0]  scnt,
    output logic [5:0]  idx
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_WAIT  = ST_WAIT;
    localparam logic [1:0] S_BURST = ST_BURST;
    localparam logic [5:0] NMAX    = 6'(TRACE_WD);

    logic [1:0]  state_q, state_d;
    logic [15:0] dcnt_q, dcnt_d;
    logic [5:0]  scnt_q, scnt_d;
    logic [5:0]  idx_q, idx_d;
    logic [5:0]  nsamp_c;

    assign nsamp_c = (nsamp > NMAX) ? NMAX : nsamp;

    // next state: abort beats start, start restarts from any state
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        scnt_d  = scnt_q;
        idx_d   = idx_q;
        done    = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            scnt_d  = '0;
        end else if (start) begin
            state_d = S_WAIT;
            dcnt_d  = delay;
            scnt_d  = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (dcnt_q == 16'd0) begin
                        if (nsamp_c == 6'd0) begin
                            state_d = S_IDLE;
                            done    = 1'b1;
                        end else begin
                            state_d = S_BURST;
                            scnt_d  = nsamp_c;
                        end
                    end else begin
                        dcnt_d = dcnt_q - 16'd1;
                    end
                end
                S_BURST: begin
                    idx_d  = idx_q + 6'd1;
                    scnt_d = scnt_q - 6'd1;
                    if (scnt_q == 6'd1) begin
                        state_d = S_IDLE;
                        done    = 1'b1;
                    end
                end
                S_IDLE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // sequencer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dcnt_q  <= '0;
            scnt_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            scnt_q  <= scnt_d;
            idx_q   <= idx_d;
        end
    end

    assign dma_en = (state_q == S_BURST);
    assign busy   = (state_q != S_IDLE);
    assign scnt   = scnt_q;
    assign idx    = idx_q;

endmodule

// File: rtl/dma_trace_probe.sv
// dma_trace_probe top
// register file, trace shifter, read mux, dma drive
module dma_trace_probe
    import dma_probe_pkg::*;
#(
    parameter logic [14:0] BASE_ADDR = 15'h0070,
    parameter int          DEC_WD    = 4,
    parameter int          TRACE_WD  = 32
) (
    input  logic              mclk,
    input  logic              puc_rst_n,
    dma_trace_probe_if.slave  bus
);

    if (!trace_wd_ok(TRACE_WD)) begin : g_bad_trace_wd
        $error("dma_trace_probe: TRACE_WD must be 16, 32 or 48");
    end

    logic        sel, wr_en, rd_en;
    logic [15:0] off;
    logic        wr_ctrl, start, abort, start_go;
    logic [14:0] addr_q, addr_d;
    logic [15:0] delay_q, delay_d;
    logic [5:0]  nsamp_q, nsamp_d;
    logic        wr_q, wr_d;
    logic        inc_q, inc_d;
    logic        ie_q, ie_d;
    logic [15:0] wdata_q, wdata_d;
    logic        done_q, done_d;
    logic [TRACE_WD-1:0] trace_q, trace_d;
    logic [47:0] trace_ext;
    logic [15:0] rdata;
    logic        seq_en, seq_busy, seq_done;
    logic [5:0]  seq_scnt, seq_idx;

    assign sel = bus.per_en &&
                 (bus.per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
    assign off      = 16'({bus.per_addr[DEC_WD-2:0], 1'b0});
    assign wr_en    = sel && (bus.per_we != 2'b00);
    assign rd_en    = sel && (bus.per_we == 2'b00);
    assign wr_ctrl  = wr_en && (off == OFF_CTRL);
    assign start    = wr_ctrl && bus.per_din[CTRL_START];
    assign abort    = wr_ctrl && bus.per_din[CTRL_ABORT];
    assign start_go = start && !abort;

    dma_probe_seq #(
        .TRACE_WD (TRACE_WD)
    ) u_seq (
        .clk    (mclk),
        .rst_n  (puc_rst_n),
        .start  (start),
        .abort  (abort),
        .delay  (delay_q),
        .nsamp  (nsamp_q),
        .dma_en (seq_en),
        .busy   (seq_busy),
        .done   (seq_done),
        .scnt   (seq_scnt),
        .idx    (seq_idx)
    );

    // register writes, sticky done, trace capture
    always_comb begin
        addr_d  = addr_q;
        delay_d = delay_q;
        nsamp_d = nsamp_q;
        wr_d    = wr_q;
        inc_d   = inc_q;
        ie_d    = ie_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        trace_d = trace_q;
        if (wr_en && off == OFF_ADDR)  addr_d  = bus.per_din[15:1];
        if (wr_en && off == OFF_DELAY) delay_d = bus.per_din;
        if (wr_en && off == OFF_WDATA) wdata_d = bus.per_din;
        if (wr_ctrl) begin
            nsamp_d = bus.per_din[NSAMP_WD-1:0];
            wr_d    = bus.per_din[CTRL_WR];
            inc_d   = bus.per_din[CTRL_INC];
            ie_d    = bus.per_din[CTRL_IE];
        end
        if (seq_done)
            done_d = 1'b1;
        else if (start_go)
            done_d = 1'b0;
        else if (wr_en && off == OFF_STATUS && bus.per_din[STAT_DONE])
            done_d = 1'b0;
        if (start_go)
            trace_d = '0;
        else if (seq_en)
            trace_d = {trace_q[TRACE_WD-2:0], ~bus.dma_ready};
    end

    // register file flops
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            addr_q  <= '0;
            delay_q <= '0;
            nsamp_q <= '0;
            wr_q    <= 1'b0;
            inc_q   <= 1'b0;
            ie_q    <= 1'b0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            trace_q <= '0;
        end else begin
            addr_q  <= addr_d;
            delay_q <= delay_d;
            nsamp_q <= nsamp_d;
            wr_q    <= wr_d;
            inc_q   <= inc_d;
            ie_q    <= ie_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            trace_q <= trace_d;
        end
    end

    assign trace_ext = 48'(trace_q);

    // zero-wait read mux
    always_comb begin
        rdata = '0;
        if (rd_en) begin
            unique case (1'b1)
                off == OFF_ADDR:   rdata = {addr_q, 1'b0};
                off == OFF_DELAY:  rdata = delay_q;
                off == OFF_CTRL:   rdata = {5'b0, ie_q, inc_q, wr_q,
                                            2'b0, nsamp_q};
                off == OFF_STATUS: rdata = {2'b0, seq_scnt, 6'b0,
                                            done_q, seq_busy};
                off == OFF_WDATA:  rdata = wdata_q;
                off == OFF_TRACE0: rdata = trace_ext[15:0];
                off == OFF_TRACE1: rdata = trace_ext[31:16];
                off == OFF_TRACE2: rdata = trace_ext[47:32];
                default:           rdata = '0;
            endcase
        end
    end

    assign bus.per_dout = rdata;
    assign bus.dma_en   = seq_en;
    assign bus.dma_addr = seq_en ?
                          addr_q + (inc_q ? 15'(seq_idx) : 15'd0) : 15'd0;
    assign bus.dma_we   = (seq_en && wr_q) ? 2'b11 : 2'b00;
    assign bus.dma_dout = (seq_en && wr_q) ? wdata_q : 16'h0000;
    assign bus.irq      = done_q & ie_q;

endmodule

// File: doc/dma_trace_probe.md
# dma_trace_probe

Parametrised, multi-sample DMA contention probe on the openMSP430 peripheral bus. Software programs a target address, a start delay, a sample count and a mode. The block then waits the programmed delay and issues a burst of back-to-back DMA requests, either reads or writes. For every request it records one stall bit (`~dma_ready`) in a trace register of up to 48 bits. The block is the parametrised successor of the single-shot 16-bit DMA attacker. Over that block it adds a variable trace width, a sample count, write mode, address auto-increment, abort, done status and an interrupt.

## Interface
Parameters:
- `BASE_ADDR`, default 15'h0070: byte base address, aligned to 2^DEC_WD.
- `DEC_WD`, default 4: decoder width, 16 bytes = 8 word registers.
- `TRACE_WD`, default 32: trace length in bits. Legal values are 16, 32 and 48; any other value is an elaboration error.

Ports:
- `mclk` in 1: main system clock. All state is on the rising edge.
- `puc_rst_n` in 1: asynchronous, active-low reset.
- `per_addr` in 14: peripheral word address.
- `per_din` in 16: peripheral write data.
- `per_en` in 1: peripheral enable.
- `per_we` in 2: byte write enables. Any nonzero value is treated as a full-word write.
- `per_dout` out 16: read data. Combinational from the selected register; 0 when not selected.
- `dma_addr` out 15: DMA word address.
- `dma_dout` out 16: DMA write data.
- `dma_en` out 1: DMA request.
- `dma_we` out 2: DMA byte write enables.
- `dma_ready` in 1: DMA grant. Low means the request is stalled.
- `irq` out 1: done interrupt, level-sensitive.

## Operation
Registers (byte offset):
- **0x0 ADDR**: target byte address; bit 0 is ignored.
- **0x2 DELAY**: 16-bit start delay D.
- **0x4 CTRL**:
  - [5:0] NSAMP (sample count).
  - [8] WR: 1 = write mode, 0 = read mode.
  - [9] INC: address auto-increment.
  - [10] IE: interrupt enable.
  - [14] ABORT: write-1 pulse, reads as 0.
  - [15] START: write-1 pulse, reads as 0.
- **0x6 STATUS**:
  - [0] BUSY.
  - [1] DONE, sticky; writing 1 to this bit clears it.
  - [13:8] samples remaining.
- **0x8 WDATA**: data driven on `dma_dout` in write mode.
- **0xA/0xC/0xE TRACE0..2**: TRACE[15:0], [31:16], [47:32]. Words at or beyond TRACE_WD read as 0. TRACE is read-only; writes are ignored.

NSAMP is clamped to TRACE_WD. NSAMP = 0 completes immediately: DONE is set and no request is issued.

FSM states:
- **IDLE**: no requests issued.
- **WAIT**: delay counter `dcnt` loaded with D; decrements each cycle.
- **BURST**: sample counter `scnt` loaded with NSAMP; one request per cycle.

Transitions:
- IDLE/WAIT/BURST → WAIT on START. Effects: TRACE, DONE and the sample index are cleared.
- WAIT → BURST when `dcnt == 0`. If NSAMP = 0, go to IDLE with DONE set instead.
- BURST → IDLE after the request with `scnt == 1` completes; DONE is set.
- any state → IDLE on ABORT. DONE is unchanged and TRACE is preserved.
- START and ABORT written in the same cycle: ABORT wins.

Request rules in BURST:
- `dma_en` = 1 every cycle. The block does not wait for `dma_ready` (fire-and-forget).
- At each edge with `dma_en` = 1, TRACE shifts left by one and `~dma_ready` enters bit 0.
- Sample index i runs 0..NSAMP-1. `dma_addr` = ADDR[15:1] + (INC ? i : 0), wrapping modulo 2^15.
- `dma_we` = WR ? 2'b11 : 2'b00.
- `dma_dout` = WR ? WDATA : 0.

Register writes during a run:
- ADDR, WDATA and CTRL[9:8] changes take effect on the next request.
- DELAY and NSAMP are sampled only at START and BURST entry respectively.

Interrupt: `irq` = DONE & IE.

Reset: all registers, TRACE and counters are 0, and the FSM is in IDLE. Outputs `dma_en`, `dma_we`, `dma_addr`, `dma_dout` and `irq` are all 0. Reset asserted mid-burst drops `dma_en` asynchronously.

## Timing
- START captured at edge E0 → `dma_en` first high at edge E0+D+1 (registered output). D = 0 gives one cycle of latency.
- Burst length is exactly NSAMP consecutive cycles of `dma_en`. `dma_en` falls, and DONE and BUSY update, at edge E0+D+1+NSAMP.
- The trace bit for request k is captured at the edge ending request k's cycle.
- `per_dout` is valid in the same cycle as `per_en`, with zero wait states.
- STATUS[13:8] decrements at each burst edge.

## Structure
- Package `dma_probe_pkg`:
  - register offsets;
  - CTRL and STATUS bit indices;
  - FSM state enum (IDLE, WAIT, BURST);
  - legal TRACE_WD check.
- Top `dma_trace_probe`: decoder, register file, TRACE shift register, read mux.
- Sub-module `dma_probe_seq`:
  - contains the FSM, `dcnt` and `scnt`, and the sample index;
  - outputs `dma_en`, `busy` and a `done` pulse;
  - takes `start` and `abort` pulses, D and NSAMP as inputs.

## Test plan
- **Read burst:** ADDR=0x0200, D=3, NSAMP=4, INC=1, `dma_ready` stuck 1.
  - `dma_en` high at E0+4..E0+7.
  - `dma_addr` 0x100, 0x101, 0x102, 0x103.
  - TRACE0 = 0x0000, DONE = 1.
- **Stall pattern:** NSAMP=8, `dma_ready` = 1,0,0,1,1,1,0,1 → TRACE0 = 0x0062.
- **Write mode with 48-bit trace:** TRACE_WD=48, NSAMP=40, WR=1, WDATA=0xA5A5, INC=0.
  - 40 requests, all with `dma_we`=11, `dma_dout`=0xA5A5, `dma_addr` constant.
  - TRACE2 reads 0x0000 upper bits beyond the 40 captured.
- **Boundaries:**
  - NSAMP=0 → DONE with no `dma_en`.
  - NSAMP=63 with TRACE_WD=32 → exactly 32 requests.
  - ADDR=0xFFFE with INC → `dma_addr` wraps 0x7FFF→0x0000.
- **Control:**
  - ABORT mid-burst → `dma_en` low next edge, DONE stays 0.
  - START mid-WAIT restarts the delay from D and clears TRACE.
  - START+ABORT in the same write → IDLE.
- **Reset and IRQ:**
  - `puc_rst_n` low mid-burst → `dma_en` 0 immediately; all registers read 0 after release.
  - IE=1 → `irq` rises with DONE and clears on STATUS write 0x0002.
